// File: rtl/dcache_lsu_pkg.sv
// Shared definitions for the dcache load/store front-end: funct3 encodings,
// FSM state encoding and the access-size helper.
package dcache_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        ST_WR,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    // Access size in bytes; the unsigned variants share the low two bits.
    function automatic logic [2:0] lane_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   lane_size = 3'd1;
            2'b01:   lane_size = 3'd2;
            default: lane_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dcache_lsu_lane_align.sv
// Combinational byte-lane steering: extended load extraction from a word and
// sub-word merge of store data into an old word.
module lsu_lane_align
    import dcache_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [2:0]  size,
    output logic [31:0] ext_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] lane_data;
    logic [31:0] mask;

    assign shamt = {lane, 3'b000};

    always_comb begin
        lane_data = word >> shamt;
        case (funct3)
            F3_B:    ext_data = {{24{lane_data[7]}}, lane_data[7:0]};
            F3_H:    ext_data = {{16{lane_data[15]}}, lane_data[15:0]};
            F3_BU:   ext_data = {24'h0, lane_data[7:0]};
            F3_HU:   ext_data = {16'h0, lane_data[15:0]};
            default: ext_data = word;
        endcase

        case (size)
            3'd1:    mask = 32'h0000_00FF;
            3'd2:    mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask   = mask << shamt;
        merged = (old_word & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/dcache_lsu.sv
// RV32I load/store front-end for the word-wide dcache SRAM; sub-word stores
// are performed as read-modify-write.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// LD_RD  | SRAM read, extended lane captured for the response
// ST_WR  | full-word store written straight to SRAM
// RMW_RD | SB/SH: read the old word
// RMW_WR | SB/SH: write the merged word back
// RESP   | response held until resp_ready
module dcache_lsu
    import dcache_lsu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter bit ERR_OOR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              sram_rden,
    output logic [ADDR_W-1:0] sram_rdaddress,
    input  logic [31:0]       sram_read_data,
    output logic              sram_wren,
    output logic [ADDR_W-1:0] sram_wraddress,
    output logic [31:0]       sram_write_data
);

    state_t            state, state_nxt;
    logic [ADDR_W-3:0] word_q;
    logic [1:0]        lane_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       old_q;
    logic              err_q;

    logic              accept;
    logic              misaligned;
    logic              illegal;
    logic              out_of_range;
    logic              req_err;
    logic [31:0]       ext_data;
    logic [31:0]       merged;
    logic [ADDR_W-1:0] word_addr;

    lsu_lane_align u_align (
        .word     (sram_read_data),
        .lane     (lane_q),
        .funct3   (funct3_q),
        .old_word (old_q),
        .wdata    (wdata_q),
        .size     (lane_size(funct3_q)),
        .ext_data (ext_data),
        .merged   (merged)
    );

    assign word_addr = {word_q, 2'b00};
    assign accept    = req_valid && req_ready;

    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (req_funct3)
            F3_H, F3_HU: misaligned = req_addr[0];
            F3_W:        misaligned = |req_addr[1:0];
            default:     misaligned = 1'b0;
        endcase
        if (req_we)
            illegal = !(req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W);
        else
            illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
        out_of_range = ERR_OOR && ((req_addr >> ADDR_W) != 32'h0);
        req_err      = misaligned || illegal || out_of_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = 32'h0;
        resp_err        = 1'b0;
        sram_rden       = 1'b0;
        sram_rdaddress  = '0;
        sram_wren       = 1'b0;
        sram_wraddress  = '0;
        sram_write_data = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (!req_we)
                        state_nxt = LD_RD;
                    else if (req_funct3 == F3_W)
                        state_nxt = ST_WR;
                    else
                        state_nxt = RMW_RD;
                end
            end
            LD_RD: begin
                sram_rden      = 1'b1;
                sram_rdaddress = word_addr;
                state_nxt      = RESP;
            end
            ST_WR: begin
                sram_wren       = 1'b1;
                sram_wraddress  = word_addr;
                sram_write_data = wdata_q;
                state_nxt       = RESP;
            end
            RMW_RD: begin
                sram_rden      = 1'b1;
                sram_rdaddress = word_addr;
                state_nxt      = RMW_WR;
            end
            RMW_WR: begin
                sram_wren       = 1'b1;
                sram_wraddress  = word_addr;
                sram_write_data = merged;
                state_nxt       = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                if (resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response data is cleared at accept so stores and errors return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= '0;
            lane_q   <= 2'b00;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            old_q    <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                word_q   <= req_addr[ADDR_W-1:2];
                lane_q   <= req_addr[1:0];
                funct3_q <= req_funct3;
                wdata_q  <= req_wdata;
                rdata_q  <= 32'h0;
                err_q    <= req_err;
            end
            if (state == LD_RD)
                rdata_q <= ext_data;
            if (state == RMW_RD)
                old_q <= sram_read_data;
        end
    end

endmodule
